flash_arbiter: RTL and testbench

Two-port arbiter that shares the single flash read controller between the CPU instruction/operand fetch path (port 0) and the graphics asset fetcher (port 1). Each port uses the same enable/ready read handshake the flash controller presents. The arbiter serialises requests and alternates grants round-robin under contention. It sits between both requesters and the flash controller, and flags a sticky error if the controller stalls.

---
 rtl/flash_arbiter.sv | 168 ++++++++++++++++
 tb/tb_flash_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter.sv
// rtl/flash_arbiter.sv - round-robin arbiter sharing one flash read controller between two requesters
module flash_arbiter #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_en,
  input  logic [23:0] req0_addr,
  output logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_en,
  input  logic [23:0] req1_addr,
  output logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        flash_en,
  output logic [23:0] flash_addr,
  input  logic [15:0] flash_data,
  input  logic        flash_ready,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  // Counter only has to reach TIMEOUT; keep at least one bit for tiny values.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_START = 2'd1;
  localparam logic [1:0] S_WAIT_DONE  = 2'd2;
  localparam logic [1:0] S_RELEASE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          flash_en_q, flash_en_d;
  logic [23:0]   flash_addr_q, flash_addr_d;
  logic [15:0]   data0_q, data0_d;
  logic [15:0]   data1_q, data1_d;
  logic          ready0_q, ready0_d;
  logic          ready1_q, ready1_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          win_valid;
  logic          win;
  logic          owner_en;
  logic          deliver;
  logic [15:0]   deliver_val;

  // Arbitration: a lone requester wins; on a tie the port that was not served last wins.
  always_comb begin
    win_valid = req0_en | req1_en;
    win       = (req0_en & req1_en) ? ~last_q : req1_en;
    owner_en  = grant_q ? req1_en : req0_en;
  end

  // Next-state logic for the transaction sequencer and all registered outputs.
  always_comb begin
    state_d      = state_q;
    flash_en_d   = flash_en_q;
    flash_addr_d = flash_addr_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    ready0_d     = ready0_q;
    ready1_d     = ready1_q;
    grant_d      = grant_q;
    last_d       = last_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    deliver      = 1'b0;
    deliver_val  = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          grant_d      = win;
          flash_addr_d = win ? req1_addr : req0_addr;
          flash_en_d   = 1'b1;
          if (win) ready1_d = 1'b0;
          else     ready0_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_WAIT_START;
        end
      end
      S_WAIT_START, S_WAIT_DONE: begin
        if (cnt_q == TMAX) begin
          // Controller stalled: hand the requester an all-ones word and flag it.
          flash_en_d  = 1'b0;
          deliver     = 1'b1;
          deliver_val = 16'hFFFF;
          err_d       = 1'b1;
          state_d     = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (state_q == S_WAIT_START) begin
            if (!flash_ready) state_d = S_WAIT_DONE;
          end else if (flash_ready) begin
            flash_en_d  = 1'b0;
            deliver     = 1'b1;
            deliver_val = flash_data;
            state_d     = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (!owner_en) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      if (grant_q) begin
        data1_d  = deliver_val;
        ready1_d = 1'b1;
      end else begin
        data0_d  = deliver_val;
        ready0_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      flash_en_q   <= 1'b0;
      flash_addr_q <= 24'h0;
      data0_q      <= 16'h0;
      data1_q      <= 16'h0;
      ready0_q     <= 1'b1;
      ready1_q     <= 1'b1;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      flash_en_q   <= flash_en_d;
      flash_addr_q <= flash_addr_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      ready0_q     <= ready0_d;
      ready1_q     <= ready1_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    flash_en    = flash_en_q;
    flash_addr  = flash_addr_q;
    req0_data   = data0_q;
    req1_data   = data1_q;
    req0_ready  = ready0_q;
    req1_ready  = ready1_q;
    grant       = grant_q;
    busy        = (state_q != S_IDLE);
    timeout_err = err_q;
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// tb/tb_flash_arbiter.sv - randomized and directed bench for flash_arbiter
module tb_flash_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_en, req1_en;
  logic [23:0] req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        flash_en;
  logic [23:0] flash_addr;
  logic [15:0] flash_data;
  logic        flash_ready;
  logic        grant, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  flash_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_en(req0_en), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_en(req1_en), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .flash_en(flash_en), .flash_addr(flash_addr), .flash_data(flash_data), .flash_ready(flash_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: who owns the controller and what each port has been handed.
  int          m_owner;
  bit          m_started, m_delivered;
  int          m_age;
  bit          m_last, m_grant, m_flash_en, m_err;
  logic [23:0] m_addr;
  logic [15:0] m_data [2];
  bit          m_ready [2];

  // Flash controller responder.
  int          rphase = 0;
  int          rcnt = 0;
  int          d1 = 2, d2 = 3;
  bit          stall = 0;
  bit          rand_resp = 0;
  logic [15:0] fixed_data = 16'hA5C3;
  logic [15:0] rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit en [2];
    int w;
    en[0] = req0_en;
    en[1] = req1_en;
    if (reset) begin
      m_owner = -1; m_flash_en = 0; m_addr = 0; m_grant = 0; m_last = 1; m_err = 0;
      m_age = 0; m_started = 0; m_delivered = 0;
      m_ready[0] = 1; m_ready[1] = 1; m_data[0] = 0; m_data[1] = 0;
    end else if (m_owner < 0) begin
      if (en[0] && en[1]) w = m_last ? 0 : 1;
      else if (en[0])     w = 0;
      else if (en[1])     w = 1;
      else                w = -1;
      if (w >= 0) begin
        m_owner = w; m_grant = (w == 1); m_flash_en = 1;
        m_addr = (w == 1) ? req1_addr : req0_addr;
        m_ready[w] = 0; m_age = 0; m_started = 0; m_delivered = 0;
      end
    end else if (!m_delivered) begin
      if (m_age == TO) begin
        m_flash_en = 0; m_data[m_owner] = 16'hFFFF; m_ready[m_owner] = 1;
        m_err = 1; m_delivered = 1;
      end else begin
        m_age++;
        if (!m_started) begin
          if (!flash_ready) m_started = 1;
        end else if (flash_ready) begin
          m_flash_en = 0; m_data[m_owner] = flash_data; m_ready[m_owner] = 1; m_delivered = 1;
        end
      end
    end else if (!en[m_owner]) begin
      m_last = (m_owner == 1);
      m_owner = -1;
    end
  endtask

  task automatic compare();
    chk("flash_en", {31'b0, flash_en}, {31'b0, m_flash_en});
    chk("flash_addr", {8'b0, flash_addr}, {8'b0, m_addr});
    chk("req0_data", {16'b0, req0_data}, {16'b0, m_data[0]});
    chk("req1_data", {16'b0, req1_data}, {16'b0, m_data[1]});
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, m_ready[0]});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, m_ready[1]});
    chk("grant", {31'b0, grant}, {31'b0, m_grant});
    chk("busy", {31'b0, busy}, {31'b0, (m_owner >= 0)});
    chk("timeout_err", {31'b0, timeout_err}, {31'b0, m_err});
  endtask

  task automatic resp_update();
    case (rphase)
      0: if (flash_en) begin
        if (rand_resp) begin
          stall = ($urandom_range(0, 9) == 0);
          d1 = $urandom_range(1, 3);
          d2 = $urandom_range(1, 5);
          rdata = 16'($urandom);
        end else begin
          rdata = fixed_data;
        end
        rcnt = d1;
        rphase = stall ? 4 : 1;
      end
      1: if (!flash_en) rphase = 0;
         else if (rcnt <= 1) begin flash_ready = 0; rcnt = d2; rphase = 2; end
         else rcnt--;
      2: if (!flash_en) begin flash_ready = 1; rphase = 0; end
         else if (rcnt <= 1) begin flash_ready = 1; flash_data = rdata; rphase = 3; end
         else rcnt--;
      default: if (!flash_en) begin flash_ready = 1; rphase = 0; end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
    resp_update();
  endtask

  task automatic wait_ready(input int p, input logic val);
    int n = 0;
    while (((p == 1) ? req1_ready : req0_ready) !== val && n < 200) begin
      tick();
      n++;
    end
    chk("wait_ready", {31'b0, (p == 1) ? req1_ready : req0_ready}, {31'b0, val});
  endtask

  task automatic wait_rphase2();
    int n = 0;
    while (rphase != 2 && n < 100) begin tick(); n++; end
    chk("wait_rphase", rphase, 2);
  endtask

  task automatic do_reset();
    reset = 1; req0_en = 0; req1_en = 0;
    tick(); tick();
    reset = 0;
  endtask

  bit seen_low [2];

  task automatic drive_port(input int p);
    logic en_v, rdy_v;
    en_v  = (p == 1) ? req1_en : req0_en;
    rdy_v = (p == 1) ? req1_ready : req0_ready;
    if (!en_v) begin
      if ($urandom_range(0, 2) == 0) begin
        en_v = 1; seen_low[p] = 0;
        if (p == 1) req1_addr = 24'($urandom); else req0_addr = 24'($urandom);
      end
    end else begin
      if (!rdy_v) seen_low[p] = 1;
      if (seen_low[p] && rdy_v) begin
        if ($urandom_range(0, 1) == 0) begin en_v = 0; seen_low[p] = 0; end
      end else if (!rdy_v && $urandom_range(0, 19) == 0) begin
        en_v = 0;
      end
      if ($urandom_range(0, 7) == 0) begin
        if (p == 1) req1_addr = 24'($urandom); else req0_addr = 24'($urandom);
      end
    end
    if (p == 1) req1_en = en_v; else req0_en = en_v;
  endtask

  initial begin
    int n;
    int g;
    reset = 1; req0_en = 0; req1_en = 0; req0_addr = 0; req1_addr = 0;
    flash_ready = 1; flash_data = 16'h0; rdata = 16'h0;

    do_reset();
    chk("rst_flash_en", {31'b0, flash_en}, 32'd0);
    chk("rst_ready0", {31'b0, req0_ready}, 32'd1);
    chk("rst_ready1", {31'b0, req1_ready}, 32'd1);
    chk("rst_err", {31'b0, timeout_err}, 32'd0);

    // Single CPU read.
    d1 = 2; d2 = 3; fixed_data = 16'hA5C3;
    req0_addr = 24'h000010; req0_en = 1;
    tick();
    chk("cpu_flash_en", {31'b0, flash_en}, 32'd1);
    chk("cpu_flash_addr", {8'b0, flash_addr}, 32'h10);
    chk("cpu_ready_low", {31'b0, req0_ready}, 32'd0);
    chk("cpu_grant", {31'b0, grant}, 32'd0);
    wait_ready(0, 1);
    chk("cpu_data", {16'b0, req0_data}, 32'hA5C3);
    chk("cpu_ready1", {31'b0, req1_ready}, 32'd1);
    req0_en = 0; tick(); tick();

    // Simultaneous requests after reset.
    do_reset();
    fixed_data = 16'h1111;
    req0_addr = 24'h100; req1_addr = 24'h200; req0_en = 1; req1_en = 1;
    tick();
    chk("tie_grant0", {31'b0, grant}, 32'd0);
    chk("tie_addr0", {8'b0, flash_addr}, 32'h100);
    wait_ready(0, 1);
    chk("tie_ready1_wait", {31'b0, req1_ready}, 32'd1);
    req0_en = 0; tick(); tick();
    chk("tie_grant1", {31'b0, grant}, 32'd1);
    chk("tie_addr1", {8'b0, flash_addr}, 32'h200);
    wait_ready(1, 1);
    req1_en = 0; tick();

    // Round-robin under continuous contention.
    do_reset();
    req0_addr = 24'hA00; req1_addr = 24'hB00; req0_en = 1; req1_en = 1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (!flash_en && n < 50) begin tick(); n++; end
      g = grant;
      chk("rr_grant", g, i % 2);
      wait_ready(g, 1);
      if (g == 1) req1_en = 0; else req0_en = 0;
      tick();
      if (g == 1) req1_en = 1; else req0_en = 1;
    end
    req0_en = 0; req1_en = 0;
    tick(); tick(); tick();
    n = 0;
    while (busy && n < 50) begin tick(); n++; end

    // Timeout with a controller that never starts.
    stall = 1;
    req0_addr = 24'h33; req0_en = 1;
    tick();
    chk("to_flash_en", {31'b0, flash_en}, 32'd1);
    n = 0;
    while (flash_en && n < 100) begin tick(); n++; end
    chk("to_len", n, 17);
    chk("to_data", {16'b0, req0_data}, 32'hFFFF);
    chk("to_ready", {31'b0, req0_ready}, 32'd1);
    chk("to_err", {31'b0, timeout_err}, 32'd1);
    req0_en = 0; tick(); tick();
    stall = 0; fixed_data = 16'h7E57;
    req1_addr = 24'h77; req1_en = 1;
    tick();
    wait_ready(1, 1);
    chk("to_ok_data", {16'b0, req1_data}, 32'h7E57);
    chk("to_err_sticky", {31'b0, timeout_err}, 32'd1);
    req1_en = 0; tick(); tick();

    // Requester abandons during WAIT_DONE with port 0 pending.
    d1 = 2; d2 = 4; fixed_data = 16'h1234;
    req1_addr = 24'h444; req1_en = 1;
    tick();
    wait_rphase2();
    tick();
    req1_en = 0; req0_addr = 24'h555; req0_en = 1;
    wait_ready(1, 1);
    chk("ab_data", {16'b0, req1_data}, 32'h1234);
    tick();
    chk("ab_idle", {31'b0, busy}, 32'd0);
    tick();
    chk("ab_next_grant", {31'b0, grant}, 32'd0);
    chk("ab_next_addr", {8'b0, flash_addr}, 32'h555);
    wait_ready(0, 1);
    req0_en = 0; tick(); tick();

    // Reset in the middle of a read.
    fixed_data = 16'hBEEF;
    req0_addr = 24'h66; req0_en = 1;
    tick();
    wait_rphase2();
    tick();
    reset = 1;
    tick();
    chk("mr_flash_en", {31'b0, flash_en}, 32'd0);
    chk("mr_ready0", {31'b0, req0_ready}, 32'd1);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_err", {31'b0, timeout_err}, 32'd0);
    chk("mr_addr", {8'b0, flash_addr}, 32'h0);
    reset = 0;
    tick();
    wait_ready(0, 1);
    chk("mr_data", {16'b0, req0_data}, 32'hBEEF);
    req0_en = 0; tick(); tick();

    // Randomized traffic.
    rand_resp = 1;
    seen_low[0] = 0; seen_low[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      drive_port(0);
      drive_port(1);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
